// File: rtl/sdram_cache_pkg.sv
// Shared types and helpers for the SDRAM line cache: FSM states, address field
// split and line-word select.
package sdram_cache_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_W     = 64;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL
  } state_t;

  function automatic logic [OFF_W-1:0] addr_offset(input logic [31:0] addr);
    return addr[OFF_W-1:0];
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned idx_w);
    return (addr >> OFF_W) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned idx_w);
    return addr >> (idx_w + OFF_W);
  endfunction

  // Word n of a line sits at bits [16n+15:16n].
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    return line[{off, 4'b0000} +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_ram_sp.sv
// Single-port RAM with synchronous read (one-cycle latency); read-before-write
// on the shared address.
module cache_ram_sp #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_line_cache.sv
// Direct-mapped read cache of 64-bit lines between the CPU port and the SDRAM
// controller. Optional hit/miss counters: define SDRAM_CACHE_STATS_EN.
module sdram_line_cache
  import sdram_cache_pkg::*;
#(
  parameter int unsigned LINES  = 256,
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk_96,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [15:0]       cpu_dout,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [63:0]       mem_data64,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              flush,
`ifdef SDRAM_CACHE_STATS_EN
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
`endif
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;

  state_t              state;
  logic [ADDR_W-1:0]   req_addr;
  logic [IDX_W-1:0]    clr_cnt;
  logic [LINES-1:0]    valid;
  logic                stale;
  logic                flush_pend;

  logic [IDX_W-1:0]    cpu_idx;
  logic [IDX_W-1:0]    req_idx;
  logic [IDX_W-1:0]    snoop_idx;
  logic [IDX_W-1:0]    ram_addr;
  logic [TAG_W-1:0]    req_tag;
  logic [TAG_W-1:0]    tag_rd;
  logic [OFF_W-1:0]    req_off;
  logic [LINE_W-1:0]   data_rd;
  logic                ram_we;
  logic                snoop_on_req;
  logic                lookup_hit;

  // Address field split for the live CPU address, the held request and the snoop.
  assign cpu_idx   = IDX_W'(addr_index(32'(cpu_addr), IDX_W));
  assign req_idx   = IDX_W'(addr_index(32'(req_addr), IDX_W));
  assign snoop_idx = IDX_W'(addr_index(32'(snoop_addr), IDX_W));
  assign req_tag   = TAG_W'(addr_tag(32'(req_addr), IDX_W));
  assign req_off   = addr_offset(32'(req_addr));

  // RAMs follow the CPU address while idle so the lookup read is ready next cycle.
  assign ram_addr     = (state == ST_IDLE) ? cpu_idx : req_idx;
  assign ram_we       = (state == ST_FILL) && mem_done;
  assign snoop_on_req = snoop_we && (snoop_idx == req_idx);
  assign lookup_hit   = valid[req_idx] && (tag_rd == req_tag) && !snoop_on_req;

  cache_ram_sp #(
    .DEPTH (LINES),
    .WIDTH (LINE_W),
    .AW    (IDX_W)
  ) u_data_ram (
    .clk   (clk_96),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (mem_data64),
    .rdata (data_rd)
  );

  cache_ram_sp #(
    .DEPTH (LINES),
    .WIDTH (TAG_W),
    .AW    (IDX_W)
  ) u_tag_ram (
    .clk   (clk_96),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_tag),
    .rdata (tag_rd)
  );

  always_ff @(posedge clk_96 or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      busy       <= 1'b1;
      cpu_ack    <= 1'b0;
      cpu_dout   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      req_addr   <= '0;
      stale      <= 1'b0;
      flush_pend <= 1'b0;
      valid      <= '0;
    end else begin
      cpu_ack <= 1'b0;
      if (flush) begin
        flush_pend <= 1'b1;
      end

      case (state)
        ST_CLEAR: begin
          valid[clr_cnt] <= 1'b0;
          if (clr_cnt == IDX_W'(LINES - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + IDX_W'(1);
          end
        end

        ST_IDLE: begin
          if (cpu_req) begin
            req_addr <= cpu_addr;
            state    <= ST_LOOKUP;
          end else if (flush_pend) begin
            // A flush arriving in this very cycle stays pending for another pass.
            flush_pend <= flush;
            clr_cnt    <= '0;
            busy       <= 1'b1;
            state      <= ST_CLEAR;
          end
        end

        ST_LOOKUP: begin
          if (lookup_hit) begin
            cpu_ack  <= 1'b1;
            cpu_dout <= line_word(data_rd, req_off);
            state    <= ST_IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            stale    <= 1'b0;
            state    <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (mem_done) begin
            valid[req_idx] <= !stale;
            mem_req        <= 1'b0;
            cpu_ack        <= 1'b1;
            cpu_dout       <= line_word(mem_data64, req_off);
            state          <= ST_IDLE;
          end else if (snoop_on_req) begin
            stale <= 1'b1;
          end
        end

        default: state <= ST_CLEAR;
      endcase

      // Snoop clears last so it wins over a same-cycle fill on the same index.
      if (snoop_we) begin
        valid[snoop_idx] <= 1'b0;
      end
    end
  end

`ifdef SDRAM_CACHE_STATS_EN
  // Saturating lookup outcome counters, cleared by flush.
  always_ff @(posedge clk_96 or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (flush) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == ST_LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt != 16'hFFFF) begin
          hit_cnt <= hit_cnt + 16'd1;
        end
      end else if (miss_cnt != 16'hFFFF) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdram_line_cache.sv
// Bench for sdram_line_cache: directed table, corner-case sequences and a
// randomized phase checked against a tag/valid array model.
module tb_sdram_line_cache;

  logic        clk_96 = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic [23:0] cpu_addr = '0;
  logic        cpu_ack;
  logic [15:0] cpu_dout;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [63:0] mem_data64 = '0;
  logic        snoop_we = 1'b0;
  logic [23:0] snoop_addr = '0;
  logic        flush = 1'b0;
  logic        busy;
`ifdef SDRAM_CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int fill_cnt = 0;
  int fill_delay = 1;
  logic [23:0] last_mem_addr = '0;
  int ack_viol = 0;
  int mreq_viol = 0;

  logic        model_valid [256];
  logic [13:0] model_tag   [256];

  sdram_line_cache dut (
    .clk_96     (clk_96),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ack    (cpu_ack),
    .cpu_dout   (cpu_dout),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_done   (mem_done),
    .mem_data64 (mem_data64),
    .snoop_we   (snoop_we),
    .snoop_addr (snoop_addr),
    .flush      (flush),
`ifdef SDRAM_CACHE_STATS_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk_96 = ~clk_96;

  // Backing store contents: two fixed lines, everything else derived from the address.
  function automatic logic [63:0] line_data(input logic [23:0] la);
    if (la == 24'h001234) return 64'h4444_3333_2222_1111;
    if (la == 24'h011234) return 64'h8888_7777_6666_5555;
    return {la[15:0] ^ 16'h5A5A, la[23:8], ~la[15:0], la[15:0] + 16'h0F0F};
  endfunction

  function automatic logic [15:0] exp_word(input logic [23:0] a);
    logic [63:0] ld;
    ld = line_data({a[23:2], 2'b00}) >> (16 * a[1:0]);
    return ld[15:0];
  endfunction

  function automatic logic model_hit(input logic [23:0] a);
    return model_valid[a[9:2]] && (model_tag[a[9:2]] == a[23:10]);
  endfunction

  task automatic model_fill(input logic [23:0] a);
    model_valid[a[9:2]] = 1'b1;
    model_tag[a[9:2]]   = a[23:10];
  endtask

  task automatic model_flush();
    for (int i = 0; i < 256; i++) model_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_96);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // SDRAM side: answers each fill request after fill_delay idle cycles.
  logic in_fill = 1'b0;
  int   wait_left = 0;
  always begin
    @(posedge clk_96);
    #1;
    mem_done = 1'b0;
    if (in_fill) begin
      if (wait_left == 0) begin
        mem_data64 = line_data(mem_addr);
        mem_done   = 1'b1;
        in_fill    = 1'b0;
      end else begin
        wait_left--;
      end
    end else if (mem_req && !reset) begin
      in_fill       = 1'b1;
      wait_left     = fill_delay;
      fill_cnt++;
      last_mem_addr = mem_addr;
    end
  end

  logic prev_ack = 1'b0;
  always begin
    @(posedge clk_96);
    #1;
    if (cpu_ack && prev_ack) ack_viol++;
    if (mem_req && busy) mreq_viol++;
    prev_ack = cpu_ack;
  end

  task automatic do_read(input logic [23:0] a, output logic [15:0] word,
                         output int lat, output int fills);
    int f0;
    bit got;
    got = 1'b0;
    f0 = fill_cnt;
    cpu_addr = a;
    cpu_req = 1'b1;
    lat = 0;
    word = '0;
    for (int i = 0; i < 400; i++) begin
      tick();
      lat++;
      if (cpu_ack) begin
        word = cpu_dout;
        got = 1'b1;
        break;
      end
    end
    cpu_req = 1'b0;
    fills = fill_cnt - f0;
    if (!got) chk("read_timeout", 64'(0), 64'(1));
  endtask

  task automatic check_read(input string name, input logic [23:0] a);
    logic [15:0] w;
    int lat, fills;
    logic exp_miss;
    exp_miss = !model_hit(a);
    do_read(a, w, lat, fills);
    chk({name, "_word"}, 64'(w), 64'(exp_word(a)));
    chk({name, "_fills"}, 64'(fills), 64'(exp_miss));
    if (exp_miss) chk({name, "_mem_addr"}, 64'(last_mem_addr), 64'({a[23:2], 2'b00}));
    else chk({name, "_latency"}, 64'(lat), 64'(2));
    model_fill(a);
  endtask

  task automatic snoop(input logic [23:0] a);
    snoop_addr = a;
    snoop_we = 1'b1;
    model_valid[a[9:2]] = 1'b0;
    tick();
    snoop_we = 1'b0;
  endtask

  task automatic wait_mem_req();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("mem_req_timeout", 64'(0), 64'(1));
  endtask

  // Returns cycles until busy drops (0 if it never does within the bound).
  task automatic wait_not_busy(output int n);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (!busy) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_flush();
    int n;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4 && !busy; i++) tick();
    chk("flush_busy_rise", 64'(busy), 64'(1));
    wait_not_busy(n);
    chk("flush_clear_len", 64'(n), 64'(256));
    model_flush();
  endtask

  typedef struct {
    logic [23:0] addr;
    logic        miss;
    logic [15:0] word;
  } vec_t;

  vec_t        vecs [10];
  logic [15:0] w;
  int          lat, fills, n, acks_in_busy, busy_len, acks;
  logic [23:0] ra;
  logic [13:0] rt;

  initial begin
    vecs[0] = '{addr: 24'h001234, miss: 1'b1, word: 16'h1111};
    vecs[1] = '{addr: 24'h001237, miss: 1'b0, word: 16'h4444};
    vecs[2] = '{addr: 24'h001235, miss: 1'b0, word: 16'h2222};
    vecs[3] = '{addr: 24'h011234, miss: 1'b1, word: 16'h5555};
    vecs[4] = '{addr: 24'h001236, miss: 1'b1, word: 16'h3333};
    vecs[5] = '{addr: 24'h001234, miss: 1'b0, word: 16'h1111};
    vecs[6] = '{addr: 24'h000000, miss: 1'b1, word: 16'h0F0F};
    vecs[7] = '{addr: 24'hFFFFFC, miss: 1'b1, word: 16'h0F0B};
    vecs[8] = '{addr: 24'hFFFFFF, miss: 1'b0, word: 16'hA5A6};
    vecs[9] = '{addr: 24'h000003, miss: 1'b0, word: 16'h5A5A};
    model_flush();

    // Reset values
    #2 reset = 1'b1;
    repeat (3) tick();
    chk("rst_cpu_ack", 64'(cpu_ack), 64'(0));
    chk("rst_cpu_dout", 64'(cpu_dout), 64'(0));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));

    // Clear sequence length, with a request held from the start of CLEAR
    reset = 1'b0;
    cpu_addr = 24'h000100;
    cpu_req = 1'b1;
    chk("busy_after_release", 64'(busy), 64'(1));
    acks_in_busy = 0;
    busy_len = 0;
    w = '0;
    for (int i = 1; i <= 500; i++) begin
      tick();
      if (cpu_ack && busy) acks_in_busy++;
      if (!busy && busy_len == 0) busy_len = i;
      if (cpu_ack) begin
        w = cpu_dout;
        break;
      end
    end
    cpu_req = 1'b0;
    chk("busy_len", 64'(busy_len), 64'(256));
    chk("ack_during_busy", 64'(acks_in_busy), 64'(0));
    chk("first_read_word", 64'(w), 64'(exp_word(24'h000100)));
    model_fill(24'h000100);

    // Directed table: cold miss, hits, conflict eviction, index 0 and 255
    for (int i = 0; i < 10; i++) begin
      do_read(vecs[i].addr, w, lat, fills);
      chk($sformatf("vec%0d_word", i), 64'(w), 64'(vecs[i].word));
      chk($sformatf("vec%0d_fills", i), 64'(fills), 64'(vecs[i].miss));
      if (vecs[i].miss)
        chk($sformatf("vec%0d_mem_addr", i), 64'(last_mem_addr), 64'({vecs[i].addr[23:2], 2'b00}));
      else
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(2));
      model_fill(vecs[i].addr);
    end

    // Snoop at another index keeps the line; same index drops it
    snoop(24'h001238);
    check_read("snoop_other", 24'h001234);
    snoop(24'h001235);
    check_read("snoop_same", 24'h001234);

    // Snoop during the lookup cycle forces a miss
    fork
      do_read(24'h001234, w, lat, fills);
      begin
        tick();
        snoop(24'h001234);
      end
    join
    chk("lookup_snoop_word", 64'(w), 64'(16'h1111));
    chk("lookup_snoop_fills", 64'(fills), 64'(1));
    model_fill(24'h001234);
    check_read("after_lookup_snoop", 24'h001234);

    // Snoop during FILL: data delivered, line not retained
    fill_delay = 5;
    fork
      do_read(24'h002000, w, lat, fills);
      begin
        wait_mem_req();
        snoop(24'h002001);
      end
    join
    chk("stale_fill_word", 64'(w), 64'(exp_word(24'h002000)));
    chk("stale_fill_fills", 64'(fills), 64'(1));
    check_read("stale_reread", 24'h002000);
    check_read("stale_reread2", 24'h002000);

    // Flush during FILL: CLEAR begins only after the ack
    fill_delay = 6;
    fork
      do_read(24'h003000, w, lat, fills);
      begin
        wait_mem_req();
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
    join
    chk("flush_fill_word", 64'(w), 64'(exp_word(24'h003000)));
    chk("busy_at_flush_ack", 64'(busy), 64'(0));
    tick();
    chk("busy_after_flush_ack", 64'(busy), 64'(1));
    wait_not_busy(n);
    chk("flush_clear_len", 64'(n), 64'(256));
    model_flush();
`ifdef SDRAM_CACHE_STATS_EN
    chk("hit_cnt_flushed", 64'(hit_cnt), 64'(0));
    chk("miss_cnt_flushed", 64'(miss_cnt), 64'(0));
`endif
    fill_delay = 1;
    check_read("post_flush_a", 24'h001234);
    check_read("post_flush_b", 24'h000000);
    check_read("post_flush_c", 24'h003000);
    check_read("post_flush_hit", 24'h003001);
`ifdef SDRAM_CACHE_STATS_EN
    chk("hit_cnt", 64'(hit_cnt), 64'(1));
    chk("miss_cnt", 64'(miss_cnt), 64'(3));
`endif

    // Request coinciding with a flush is served before CLEAR
    flush = 1'b1;
    fork
      check_read("flush_coincide", 24'h001234);
      begin
        tick();
        flush = 1'b0;
      end
    join
    tick();
    chk("busy_after_coincide", 64'(busy), 64'(1));
    wait_not_busy(n);
    chk("coincide_clear_len", 64'(n), 64'(256));
    model_flush();

    // Reset in FILL drops mem_req at once and the request is never acked
    fill_delay = 20;
    cpu_addr = 24'h004000;
    cpu_req = 1'b1;
    wait_mem_req();
    reset = 1'b1;
    #1;
    chk("rst_fill_mem_req", 64'(mem_req), 64'(0));
    chk("rst_fill_busy", 64'(busy), 64'(1));
    cpu_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    chk("rst_fill_no_ack", 64'(acks), 64'(0));
    chk("rst_fill_idle", 64'(busy), 64'(0));
    model_flush();

    // Randomized reads, snoops and flushes over a small aliasing address pool
    for (int k = 0; k < 250; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 3))
        0: rt = 14'h0000;
        1: rt = 14'h1001;
        2: rt = 14'h2AAA;
        default: rt = 14'h3FFF;
      endcase
      ra = {rt, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if (r < 75) begin
        fill_delay = int'($urandom_range(0, 3));
        check_read($sformatf("rnd%0d", k), ra);
      end else if (r < 94) begin
        snoop(ra);
      end else begin
        do_flush();
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    chk("ack_back_to_back", 64'(ack_viol), 64'(0));
    chk("mem_req_while_busy", 64'(mreq_viol), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
